// File: rtl/key_debounce_sync_pkg.sv
// Shared definitions for the key debouncer: FSM state encoding, qualification
// lengths for synthesis and simulation, and the reset-state helper.
package key_debounce_sync_pkg;

  // Debouncer FSM states: two stable levels, each paired with a qualifying state
  typedef enum logic [1:0] {
    S_LOW    = 2'd0,
    S_WAIT_H = 2'd1,
    S_HIGH   = 2'd2,
    S_WAIT_L = 2'd3
  } state_t;

  // Stable-cycle count for a 1 kHz sampling tick (about 20 ms of stability)
  localparam int CNT_MAX_SYNTH  = 20;
  // Same debounce window when clocked directly at 100 MHz
  localparam int CNT_MAX_100MHZ = 2_000_000;
  // Short window used in simulation so scenarios stay a few cycles long
  localparam int CNT_MAX_SIM    = 4;

  // Stable state matching the level assumed at reset
  function automatic state_t reset_state(input logic init_lvl);
    return init_lvl ? S_HIGH : S_LOW;
  endfunction

endpackage

// File: rtl/key_debounce_sync_if.sv
// Key signal bundle: the raw key input and everything the debouncer produces.
// master drives the raw key and observes the results; slave is the debouncer.
interface key_debounce_sync_if;

  logic       KEY_in;
  logic       KEY_out;
  logic       KEY_rise;
  logic       KEY_fall;
  logic       TOGGLE;
  logic [7:0] PRESS_CNT;

  modport master (
    output KEY_in,
    input  KEY_out,
    input  KEY_rise,
    input  KEY_fall,
    input  TOGGLE,
    input  PRESS_CNT
  );

  modport slave (
    input  KEY_in,
    output KEY_out,
    output KEY_rise,
    output KEY_fall,
    output TOGGLE,
    output PRESS_CNT
  );

endinterface

// File: rtl/key_debounce_sync_sync_2ff.sv
// 1-bit two-stage synchronizer. The reset value is a parameter so that the
// chain starts at the level the debouncer assumes at reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic stage1;

  // Shift the asynchronous input through two flops; only q is used downstream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage1 <= RST_VAL;
      q      <= RST_VAL;
    end else begin
      stage1 <= d;
      q      <= stage1;
    end
  end

endmodule

// File: rtl/key_debounce_sync.sv
// Key debouncer: synchronizes a bouncy key and accepts a new level only after
// it has been seen on CNT_MAX+1 consecutive edges. Produces registered level,
// rise/fall strobes, a press-toggled level and an 8-bit wrapping press count.
module key_debounce_sync
  import key_debounce_sync_pkg::*;
#(
  parameter int   CNT_MAX  = CNT_MAX_SYNTH,
  parameter int   CNT_W    = 16,
  parameter logic INIT_LVL = 1'b0
) (
  input logic               CLK,
  input logic               RST_n,
  key_debounce_sync_if.slave key
);

  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             sync2;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             toggle_q;
  logic [7:0]       press_q;

  sync_2ff #(
    .RST_VAL (INIT_LVL)
  ) u_sync (
    .clk   (CLK),
    .rst_n (RST_n),
    .d     (key.KEY_in),
    .q     (sync2)
  );

  // Next state: qualify a candidate level and restart on any single reversal
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      S_LOW: begin
        if (sync2) begin
          state_d = S_WAIT_H;
          cnt_d   = CNT_ONE;
        end
      end
      S_WAIT_H: begin
        if (!sync2) begin
          state_d = S_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LIM) begin
          state_d = S_HIGH;
          cnt_d   = '0;
          out_d   = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_HIGH: begin
        if (!sync2) begin
          state_d = S_WAIT_L;
          cnt_d   = CNT_ONE;
        end
      end
      S_WAIT_L: begin
        if (sync2) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LIM) begin
          state_d = S_LOW;
          cnt_d   = '0;
          out_d   = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = reset_state(INIT_LVL);
        cnt_d   = '0;
      end
    endcase
  end

  // Register FSM, level and strobes; toggle and count advance with each rise
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q  <= reset_state(INIT_LVL);
      cnt_q    <= '0;
      out_q    <= INIT_LVL;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      toggle_q <= 1'b0;
      press_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      if (rise_d) begin
        toggle_q <= ~toggle_q;
        press_q  <= press_q + 8'd1;
      end
    end
  end

  assign key.KEY_out   = out_q;
  assign key.KEY_rise  = rise_q;
  assign key.KEY_fall  = fall_q;
  assign key.TOGGLE    = toggle_q;
  assign key.PRESS_CNT = press_q;

endmodule

// File: tb/tb_key_debounce_sync.sv
// Bench for key_debounce_sync with a 4-cycle debounce window. Every accepted
// change is pushed as an expected strobe (kind and cycle) when the key is
// driven; a monitor pops and compares it when the strobe is due, tracking the
// expected level, toggle and press count alongside.
module tb_key_debounce_sync;
  import key_debounce_sync_pkg::*;

  localparam int LATENCY = CNT_MAX_SIM + 3;

  typedef struct {
    logic rise;
    int   cyc;
  } strobe_t;

  logic CLK;
  logic RST_n;
  int   cyc;
  int   check_count;
  int   error_count;
  int   rise_seen;
  int   fall_seen;
  logic       exp_level;
  logic       exp_toggle;
  logic [7:0] exp_cnt;
  strobe_t    exp_q[$];

  key_debounce_sync_if key_bus ();

  key_debounce_sync #(
    .CNT_MAX  (CNT_MAX_SIM),
    .CNT_W    (16),
    .INIT_LVL (1'b0)
  ) dut (
    .CLK   (CLK),
    .RST_n (RST_n),
    .key   (key_bus.slave)
  );

  // Free-running 10 ns clock
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Count active edges so expected strobes can be tagged with their cycle
  always @(posedge CLK) cyc <= cyc + 1;

  // Hard stop in case the run ever stalls
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at cycle %0d", tag, observed, expected, cyc);
    end
  endtask

  // Drive a key level (called just after an active edge), optionally expect
  // it to be accepted, and hold it for the given number of cycles
  task automatic applyStimulus(input logic lvl, input int hold, input logic accept);
    strobe_t s;
    key_bus.KEY_in = lvl;
    if (accept) begin
      s.rise = lvl;
      s.cyc  = cyc + LATENCY;
      exp_q.push_back(s);
    end
    repeat (hold) begin
      @(posedge CLK);
      #2;
    end
  endtask

  task automatic applyReset(input int hold);
    RST_n          = 1'b0;
    key_bus.KEY_in = 1'b0;
    repeat (hold) begin
      @(posedge CLK);
      #2;
    end
    RST_n = 1'b1;
  endtask

  // Scoreboard monitor: sample on the falling edge, pop strobes that are due
  task automatic monitorOutputs();
    logic exp_rise;
    logic exp_fall;
    forever begin
      @(negedge CLK);
      exp_rise = 1'b0;
      exp_fall = 1'b0;
      if (!RST_n) begin
        exp_q.delete();
        exp_level  = 1'b0;
        exp_toggle = 1'b0;
        exp_cnt    = 8'd0;
      end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        if (exp_q[0].rise) begin
          exp_rise   = 1'b1;
          exp_level  = 1'b1;
          exp_toggle = ~exp_toggle;
          exp_cnt    = exp_cnt + 8'd1;
        end else begin
          exp_fall  = 1'b1;
          exp_level = 1'b0;
        end
        void'(exp_q.pop_front());
      end
      if (key_bus.KEY_rise) rise_seen++;
      if (key_bus.KEY_fall) fall_seen++;
      checkOutput("key_rise", 32'(key_bus.KEY_rise), 32'(exp_rise));
      checkOutput("key_fall", 32'(key_bus.KEY_fall), 32'(exp_fall));
      checkOutput("key_out", 32'(key_bus.KEY_out), 32'(exp_level));
      checkOutput("toggle", 32'(key_bus.TOGGLE), 32'(exp_toggle));
      checkOutput("press_cnt", 32'(key_bus.PRESS_CNT), 32'(exp_cnt));
    end
  endtask

  // Scenario sequence
  initial begin
    int rise_base;
    int fall_base;
    check_count    = 0;
    error_count    = 0;
    rise_seen      = 0;
    fall_seen      = 0;
    cyc            = 0;
    exp_level      = 1'b0;
    exp_toggle     = 1'b0;
    exp_cnt        = 8'd0;
    RST_n          = 1'b0;
    key_bus.KEY_in = 1'b1;
    fork
      monitorOutputs();
    join_none

    // Reset held with the key high: all outputs stay at reset values
    repeat (3) @(posedge CLK);
    #2;
    checkOutput("reset_outputs",
                {21'd0, key_bus.KEY_out, key_bus.KEY_rise, key_bus.KEY_fall,
                 key_bus.TOGGLE, key_bus.PRESS_CNT}, 32'd0);
    key_bus.KEY_in = 1'b0;
    RST_n          = 1'b1;
    applyStimulus(1'b0, 20, 1'b0);

    // Clean press, then release
    applyStimulus(1'b1, 10, 1'b1);
    checkOutput("press_toggle", 32'(key_bus.TOGGLE), 32'd1);
    checkOutput("press_count", 32'(key_bus.PRESS_CNT), 32'd1);
    applyStimulus(1'b0, 10, 1'b1);
    checkOutput("release_out", 32'(key_bus.KEY_out), 32'd0);
    checkOutput("release_toggle", 32'(key_bus.TOGGLE), 32'd1);

    // Bounce every 2 cycles for 16 cycles, then settle high
    applyReset(2);
    applyStimulus(1'b0, 5, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus((i % 2) == 0, 2, 1'b0);
    applyStimulus(1'b1, 10, 1'b1);
    checkOutput("bounce_count", 32'(key_bus.PRESS_CNT), 32'd1);
    applyStimulus(1'b0, 10, 1'b1);

    // Reset lands mid-qualification: no strobe, back to reset state
    applyStimulus(1'b1, 4, 1'b0);
    applyReset(2);
    applyStimulus(1'b0, 15, 1'b0);
    checkOutput("abort_out", 32'(key_bus.KEY_out), 32'd0);
    checkOutput("abort_count", 32'(key_bus.PRESS_CNT), 32'd0);
    checkOutput("abort_toggle", 32'(key_bus.TOGGLE), 32'd0);

    // 256 clean presses wrap the press counter back to zero
    rise_base = rise_seen;
    fall_base = fall_seen;
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'b1, 8, 1'b1);
      applyStimulus(1'b0, 8, 1'b1);
    end
    applyStimulus(1'b0, 4, 1'b0);
    checkOutput("wrap_count", 32'(key_bus.PRESS_CNT), 32'd0);
    checkOutput("wrap_toggle", 32'(key_bus.TOGGLE), 32'd0);
    checkOutput("wrap_rises", 32'(rise_seen - rise_base), 32'd256);
    checkOutput("wrap_falls", 32'(fall_seen - fall_base), 32'd256);
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/key_debounce_sync.md
# key_debounce_sync

Conditions an asynchronous, bouncy input such as a push-button or switch into a clean, single-clock-domain level. It also produces one-cycle rise and fall strobes, a press-toggled level and a press counter. It sits directly upstream of the synchronous D flip-flop stage and drives that stage's D input, so bench stimulus no longer needs hand-crafted clean edges. Rising-edge clocked; all outputs registered.

## Interface
- CNT_MAX, default 20: consecutive stable cycles required to accept a new level; legal range ≥2.
- CNT_W, default 16: counter width; must satisfy 2^CNT_W > CNT_MAX.
- INIT_LVL, default 1'b0: level assumed for KEY_in at reset.
- CLK  input  1  system clock, rising edge active.
- RST_n  input  1  reset; one clock, reset asynchronous, active-low.
- KEY_in  input  1  raw asynchronous input; may glitch at any time.
- KEY_out  output  1  debounced level; feeds D of the downstream flip-flop.
- KEY_rise  output  1  one-cycle strobe on an accepted 0→1 change.
- KEY_fall  output  1  one-cycle strobe on an accepted 1→0 change.
- TOGGLE  output  1  inverts on every KEY_rise.
- PRESS_CNT  output  8  count of KEY_rise events; wraps 255→0.

## Operation
- Two-flop synchronizer, sync1 then sync2, samples KEY_in. Only sync2 is used downstream.
- FSM states:
  - S_LOW: stable 0. If sync2=1, go to S_WAIT_H with cnt=1.
  - S_WAIT_H: if sync2=0, return to S_LOW with cnt=0. If sync2=1 and cnt<CNT_MAX, cnt++. If sync2=1 and cnt=CNT_MAX, go to S_HIGH, set KEY_out=1, pulse KEY_rise, cnt=0.
  - S_HIGH and S_WAIT_L mirror S_LOW and S_WAIT_H with the polarity inverted. Acceptance pulses KEY_fall.
- Net effect: a new level is accepted only after sync2 holds it on CNT_MAX+1 consecutive sampled edges. Any single-cycle reversal restarts the qualification from zero.
- KEY_rise and KEY_fall are never both 1. Each is high for exactly one cycle per accepted change.
- TOGGLE and PRESS_CNT update on the same edge that asserts KEY_rise.
- Counter saturation cannot occur because qualification ends at CNT_MAX.
- Reset values (asynchronous, immediate on RST_n=0):
  - sync1 = sync2 = KEY_out = INIT_LVL.
  - FSM = S_LOW if INIT_LVL=0, else S_HIGH.
  - cnt = 0.
  - KEY_rise = KEY_fall = 0.
  - TOGGLE = 0.
  - PRESS_CNT = 0.
- Reset deassertion is used directly, without a reset synchronizer. The first active edge after release behaves as a normal sampling edge.

## Timing
- Edge E0 is the first edge that samples a new, held KEY_in value:
  - sync2 changes at E1.
  - KEY_out, KEY_rise or KEY_fall, TOGGLE and PRESS_CNT change at E(CNT_MAX+2).
  - Total latency is CNT_MAX+3 edges, counting E0.
- For CNT_MAX=4, KEY_out changes at E6.
- Strobe width is exactly one cycle.
- Back-to-back accepted changes are at least CNT_MAX+1 cycles apart.
- Reset asserted mid-qualification aborts it. No strobe is emitted, and outputs return to their reset values in the same instant.
- If KEY_in equals INIT_LVL throughout, there is no output activity after reset.

## Structure
- Shared package holds:
  - FSM state encoding: S_LOW, S_WAIT_H, S_HIGH, S_WAIT_L as 2-bit localparams.
  - Default CNT_MAX for synthesis, 20 at a 1 kHz tick or 2_000_000 at 100 MHz.
  - Sim value CNT_MAX=4.
- One natural sub-module: sync_2ff, a 1-bit two-stage synchronizer with reset value parameter, instantiated once. The FSM, counter and outputs live in the top module.

## Test plan
All scenarios use CNT_MAX=4, INIT_LVL=0, 10 ns clock.
1. Reset check. Hold RST_n=0 for 3 cycles while driving KEY_in=1 → all outputs 0. Release RST_n with KEY_in=0 → no strobes for 20 cycles.
2. Clean press. KEY_in 0→1 before E0 and held → KEY_out=1 and KEY_rise=1 at E6 only. TOGGLE becomes 1 and PRESS_CNT becomes 1 at E6.
3. Bounce rejection. KEY_in toggles every 2 cycles for 16 cycles, then settles to 1 → exactly one KEY_rise, six edges after the final settle sample. PRESS_CNT=1.
4. Release. From the stable-high state of scenario 2, drive KEY_in to 0 and hold → KEY_fall pulses once at E6. KEY_out=0. TOGGLE stays 1.
5. Reset mid-qualification. KEY_in rises; assert RST_n=0 at E3 → KEY_rise is never asserted. KEY_out stays 0. The state after release equals the scenario 1 state.
6. Counter wrap. Issue 256 clean presses → PRESS_CNT returns to 0. TOGGLE=0. Exactly 256 KEY_rise and 256 KEY_fall strobes are counted.
